// File: rtl/mat_pkg.sv
// Shared state encoding and sizing helpers for the matrix loader.
// The state enum also serves as the one-hot-free 2-bit encoding used by the FSM.
package mat_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Never returns less than 1 so a one-slot matrix still gets a real index bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int slot_off(input int idx, input int bitw);
      return idx * bitw;
   endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Modulo-limit element index shared by the A and B load phases.
// The limit is an input so the wrap point can change with the phase.
module mat_idx_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   input  logic [W:0]   limit,
   output logic [W-1:0] idx,
   output logic         last
);

   assign last = ({1'b0, idx} == (limit - 1'b1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (inc) begin
         idx <= last ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/mat_loader.sv
// Serial-to-parallel loader: packs row-major A then B elements into flat buses
// and holds them with mats_valid until the consumer accepts.
module mat_loader
   import mat_pkg::*;
#(
   parameter int Bit = 3,
   parameter int N   = 2,
   parameter int M   = 2,
   parameter int P   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_enable,
   input  logic             clear,
   input  logic [Bit-1:0]   data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic [Bit*N*M-1:0] matriz_A,
   output logic [Bit*M*P-1:0] matriz_B,
   output logic             mats_valid,
   input  logic             mats_ready,
   output logic             loading_b
);

   localparam int AS   = N * M;
   localparam int BS   = M * P;
   localparam int MAXS = (AS > BS) ? AS : BS;
   localparam int IW   = clog2(MAXS);

   state_t        state;
   logic [IW-1:0] idx;
   logic [IW:0]   limit;
   logic          last;
   logic          acc;
   logic          take;

   assign data_ready = (state == LOAD_A) || (state == LOAD_B);
   assign acc        = clk_enable & data_valid & data_ready;
   // clear drops any element presented in the same cycle
   assign take       = acc & ~clear;
   assign limit      = (state == LOAD_B) ? (IW+1)'(BS) : (IW+1)'(AS);

   mat_idx_counter #(
      .W (IW)
   ) u_idx (
      .clk   (clk),
      .rst   (rst),
      .inc   (take),
      .clr   (clk_enable & clear),
      .limit (limit),
      .idx   (idx),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD_A;
         matriz_A   <= '0;
         matriz_B   <= '0;
         mats_valid <= 1'b0;
         loading_b  <= 1'b0;
      end else if (clk_enable) begin
         if (clear) begin
            state      <= LOAD_A;
            mats_valid <= 1'b0;
            loading_b  <= 1'b0;
         end else begin
            case (state)
               LOAD_A: if (take) begin
                  for (int s = 0; s < AS; s++)
                     if (idx == IW'(s)) matriz_A[slot_off(s, Bit) +: Bit] <= data_in;
                  if (last) begin
                     state     <= LOAD_B;
                     loading_b <= 1'b1;
                  end
               end
               LOAD_B: if (take) begin
                  for (int s = 0; s < BS; s++)
                     if (idx == IW'(s)) matriz_B[slot_off(s, Bit) +: Bit] <= data_in;
                  if (last) begin
                     state      <= HOLD;
                     loading_b  <= 1'b0;
                     mats_valid <= 1'b1;
                  end
               end
               HOLD: if (mats_ready) begin
                  state      <= LOAD_A;
                  mats_valid <= 1'b0;
               end
               default: begin
                  state      <= LOAD_A;
                  mats_valid <= 1'b0;
                  loading_b  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: default 2x2x2 instance plus a 3x2x1, 4-bit instance.
module tb_mat_loader;

   logic        clk = 1'b0;
   logic        rst, ce, clear, dv, mr;
   logic [2:0]  din;
   logic        dr, mv, lb;
   logic [11:0] mat_a, mat_b;

   logic        dv1, mr1;
   logic [3:0]  din1;
   logic        dr1, mv1, lb1;
   logic [23:0] mat_a1;
   logic [7:0]  mat_b1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] v1 [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
   logic [2:0] v4 [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1};

   always #5 clk = ~clk;

   mat_loader dut (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (ce),
      .clear      (clear),
      .data_in    (din),
      .data_valid (dv),
      .data_ready (dr),
      .matriz_A   (mat_a),
      .matriz_B   (mat_b),
      .mats_valid (mv),
      .mats_ready (mr),
      .loading_b  (lb)
   );

   mat_loader #(.Bit(4), .N(3), .M(2), .P(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (1'b1),
      .clear      (1'b0),
      .data_in    (din1),
      .data_valid (dv1),
      .data_ready (dr1),
      .matriz_A   (mat_a1),
      .matriz_B   (mat_b1),
      .mats_valid (mv1),
      .mats_ready (mr1),
      .loading_b  (lb1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      rst = 1'b1; ce = 1'b1; clear = 1'b0; dv = 1'b0; mr = 1'b0; din = '0;
      dv1 = 1'b0; mr1 = 1'b0; din1 = '0;
      tick();
      tick();
      chk("rst_A",  32'(mat_a), 32'd0);
      chk("rst_B",  32'(mat_b), 32'd0);
      chk("rst_mv", 32'(mv), 32'd0);
      chk("rst_lb", 32'(lb), 32'd0);
      chk("rst_dr", 32'(dr), 32'd1);
      chk("rst_dr1", 32'(dr1), 32'd1);
      rst = 1'b0;

      // Test 1: plain stream
      dv = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = v1[i];
         tick();
         if (i == 3) chk("t1_lb_on", 32'(lb), 32'd1);
         if (i == 6) chk("t1_mv_early", 32'(mv), 32'd0);
      end
      chk("t1_mv", 32'(mv), 32'd1);
      chk("t1_A",  32'(mat_a), 32'o4321);
      chk("t1_B",  32'(mat_b), 32'o0765);
      chk("t1_dr", 32'(dr), 32'd0);
      chk("t1_lb_off", 32'(lb), 32'd0);

      // Test 2: hold with junk data, then handshake
      din = 3'd7; dv = 1'b1; mr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_A",  32'(mat_a), 32'o4321);
         chk("t2_hold_B",  32'(mat_b), 32'o0765);
         chk("t2_hold_mv", 32'(mv), 32'd1);
      end
      mr = 1'b1; dv = 1'b0;
      tick();
      mr = 1'b0;
      chk("t2_mv_drop", 32'(mv), 32'd0);
      chk("t2_dr", 32'(dr), 32'd1);

      // Test 3: clk_enable toggling, junk data on disabled cycles
      k = 0;
      dv = 1'b1;
      for (int c = 0; c < 16; c++) begin
         ce  = (c % 2 == 0);
         din = ce ? v1[k] : 3'd7;
         tick();
         if (ce) k++;
         if (c == 13) chk("t3_mv_early", 32'(mv), 32'd0);
      end
      ce = 1'b1;
      chk("t3_mv", 32'(mv), 32'd1);
      chk("t3_A",  32'(mat_a), 32'o4321);
      chk("t3_B",  32'(mat_b), 32'o0765);
      dv = 1'b0; ce = 1'b0; mr = 1'b1;
      tick();
      chk("t3_hold_ce0", 32'(mv), 32'd1);
      ce = 1'b1;
      tick();
      mr = 1'b0;
      chk("t3_release", 32'(mv), 32'd0);

      // Test 4: clear after three A elements
      dv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = v1[i];
         tick();
      end
      clear = 1'b1; din = 3'd6;
      tick();
      clear = 1'b0;
      chk("t4_dr", 32'(dr), 32'd1);
      chk("t4_mv", 32'(mv), 32'd0);
      chk("t4_lb", 32'(lb), 32'd0);
      chk("t4_drop_A", 32'(mat_a), 32'o4321);
      for (int i = 0; i < 8; i++) begin
         din = v4[i];
         tick();
         if (i == 3) chk("t4_lb_on", 32'(lb), 32'd1);
         if (i == 6) chk("t4_mv_early", 32'(mv), 32'd0);
      end
      chk("t4_mv_set", 32'(mv), 32'd1);
      chk("t4_A", 32'(mat_a), 32'o4567);
      chk("t4_B", 32'(mat_b), 32'o1123);
      dv = 1'b0; mr = 1'b1;
      tick();
      mr = 1'b0;

      // Test 5: reset in the middle of B
      dv = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din = v1[i];
         tick();
      end
      chk("t5_lb_pre", 32'(lb), 32'd1);
      rst = 1'b1; din = 3'd7;
      tick();
      rst = 1'b0; dv = 1'b0;
      chk("t5_A",  32'(mat_a), 32'd0);
      chk("t5_B",  32'(mat_b), 32'd0);
      chk("t5_mv", 32'(mv), 32'd0);
      chk("t5_lb", 32'(lb), 32'd0);
      chk("t5_dr", 32'(dr), 32'd1);

      // Test 6: 3x2 * 2x1 with 4-bit elements
      dv1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din1 = 4'(i + 1);
         tick();
         chk("t6_lb", 32'(lb1), 32'(i == 5 || i == 6));
         chk("t6_mv", 32'(mv1), 32'(i == 7));
      end
      dv1 = 1'b0;
      chk("t6_A",  32'(mat_a1), 32'h654321);
      chk("t6_B",  32'(mat_b1), 32'h87);
      chk("t6_dr", 32'(dr1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
